// File: rtl/ray_pkg.sv
// ray_pkg: shared state encoding, basis-vector type and default widths for the ray generator
package ray_pkg;
    localparam int RG_COORD_W   = 11;
    localparam int RG_DIM_W     = 13;
    localparam int RG_DIR_W     = 32;
    localparam int RG_IDX_W     = 26;
    localparam int RG_MAX_CORES = 8;

    typedef enum logic [1:0] {RG_IDLE, RG_INIT, RG_RUN} rg_state_t;

    typedef struct packed {
        logic signed [RG_COORD_W-1:0] x;
        logic signed [RG_COORD_W-1:0] y;
        logic signed [RG_COORD_W-1:0] z;
    } vec3_t;
endpackage

// File: rtl/ray_axis_mac.sv
// ray_axis_mac: one axis of the ray direction, dir = right*u + up*v + fwd
//   right, up, fwd : signed COORD_W basis components for this axis
//   u, v           : signed DIM_W+1 pixel offsets from the image centre
//   dir            : signed DIR_W sum, products sign-extended, no saturation
module ray_axis_mac
    import ray_pkg::*;
#(
    parameter int COORD_W = RG_COORD_W,
    parameter int DIM_W   = RG_DIM_W,
    parameter int DIR_W   = RG_DIR_W
) (
    input  logic signed [COORD_W-1:0] right,
    input  logic signed [COORD_W-1:0] up,
    input  logic signed [COORD_W-1:0] fwd,
    input  logic signed [DIM_W:0]     u,
    input  logic signed [DIM_W:0]     v,
    output logic signed [DIR_W-1:0]   dir
);
    localparam int PW = COORD_W + DIM_W + 1;

    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pu;

    always_comb begin
        pr  = PW'(right) * PW'(u);
        pu  = PW'(up) * PW'(v);
        dir = DIR_W'(pr) + DIR_W'(pu) + DIR_W'(fwd);
    end
endmodule

// File: rtl/ray_gen_strided.sv
// ray_gen_strided: strided primary-ray generator for one core of an N-core tracing array
//   clk, reset              : single clock, synchronous active-high reset
//   start, abort            : frame start (IDLE only) and synchronous frame cancel
//   core_id, num_cores      : this core's slot and the core count N
//   image_width/height      : frame size W x H
//   cam_fwd/right/up_*      : signed camera basis, shadowed at start
//   ray_valid/ready         : output beat handshake
//   ray_dir_*, pixel_*      : beat payload (direction, x, y, y*W+x)
//   ray_last, busy, done    : framing; done pulses after the final handshake
//   cfg_err                 : pulses when a start is rejected for bad configuration
module ray_gen_strided
    import ray_pkg::*;
#(
    parameter int COORD_W   = RG_COORD_W,
    parameter int DIM_W     = RG_DIM_W,
    parameter int DIR_W     = RG_DIR_W,
    parameter int IDX_W     = RG_IDX_W,
    parameter int MAX_CORES = RG_MAX_CORES,
    localparam int CID_W    = $clog2(MAX_CORES),
    localparam int NC_W     = $clog2(MAX_CORES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CID_W-1:0]          core_id,
    input  logic [NC_W-1:0]           num_cores,
    input  logic [DIM_W-1:0]          image_width,
    input  logic [DIM_W-1:0]          image_height,
    input  logic signed [COORD_W-1:0] cam_fwd_x,
    input  logic signed [COORD_W-1:0] cam_fwd_y,
    input  logic signed [COORD_W-1:0] cam_fwd_z,
    input  logic signed [COORD_W-1:0] cam_right_x,
    input  logic signed [COORD_W-1:0] cam_right_y,
    input  logic signed [COORD_W-1:0] cam_right_z,
    input  logic signed [COORD_W-1:0] cam_up_x,
    input  logic signed [COORD_W-1:0] cam_up_y,
    input  logic signed [COORD_W-1:0] cam_up_z,
    output logic                      ray_valid,
    input  logic                      ray_ready,
    output logic signed [DIR_W-1:0]   ray_dir_x,
    output logic signed [DIR_W-1:0]   ray_dir_y,
    output logic signed [DIR_W-1:0]   ray_dir_z,
    output logic [DIM_W-1:0]          pixel_x,
    output logic [DIM_W-1:0]          pixel_y,
    output logic [IDX_W-1:0]          pixel_index,
    output logic                      ray_last,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);
    rg_state_t state_q, state_d;
    logic busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d, valid_q, valid_d, last_q, last_d;
    logic signed [DIR_W-1:0] dir_x_q, dir_x_d, dir_y_q, dir_y_d, dir_z_q, dir_z_d;
    logic [DIM_W-1:0] px_q, px_d, py_q, py_d;
    logic [IDX_W-1:0] pidx_q, pidx_d;
    logic [DIM_W-1:0] it_x_q, it_x_d, it_y_q, it_y_d;
    logic [IDX_W-1:0] it_idx_q, it_idx_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
    logic [NC_W-1:0] n_q, n_d;
    logic [CID_W-1:0] id_q, id_d;
    vec3_t fwd_q, fwd_d, right_q, right_d, up_q, up_d;

    logic [2*DIM_W-1:0] wh;
    logic cfg_bad, id_ge_wh, wrap, last_nxt;
    logic [DIM_W:0] xs;
    logic [IDX_W:0] idx_n;
    logic signed [DIM_W:0] u, v;
    logic signed [DIR_W-1:0] mac_x, mac_y, mac_z;

    // One multiplier serves both the start-time check (live inputs) and the frame (shadow copy).
    assign wh       = (state_q == RG_IDLE) ? image_width * image_height : w_q * h_q;
    assign cfg_bad  = image_width == '0 || image_height == '0 || num_cores == '0 ||
                      num_cores > NC_W'(MAX_CORES) || NC_W'(core_id) >= num_cores ||
                      image_width < DIM_W'(num_cores);
    assign id_ge_wh = (2*DIM_W)'(core_id) >= wh;

    // W >= N guarantees x+N wraps past W at most once.
    assign xs       = {1'b0, it_x_q} + (DIM_W+1)'(n_q);
    assign wrap     = xs >= {1'b0, w_q};
    assign idx_n    = {1'b0, it_idx_q} + (IDX_W+1)'(n_q);
    assign last_nxt = idx_n >= (IDX_W+1)'(wh);

    assign u = $signed({1'b0, it_x_q}) - $signed({2'b0, w_q[DIM_W-1:1]});
    assign v = $signed({2'b0, h_q[DIM_W-1:1]}) - $signed({1'b0, it_y_q});

    ray_axis_mac #(.COORD_W(COORD_W), .DIM_W(DIM_W), .DIR_W(DIR_W)) u_mac_x (
        .right(right_q.x), .up(up_q.x), .fwd(fwd_q.x), .u(u), .v(v), .dir(mac_x));
    ray_axis_mac #(.COORD_W(COORD_W), .DIM_W(DIM_W), .DIR_W(DIR_W)) u_mac_y (
        .right(right_q.y), .up(up_q.y), .fwd(fwd_q.y), .u(u), .v(v), .dir(mac_y));
    ray_axis_mac #(.COORD_W(COORD_W), .DIM_W(DIM_W), .DIR_W(DIR_W)) u_mac_z (
        .right(right_q.z), .up(up_q.z), .fwd(fwd_q.z), .u(u), .v(v), .dir(mac_z));

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        valid_d   = valid_q;
        last_d    = last_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        dir_z_d   = dir_z_q;
        px_d      = px_q;
        py_d      = py_q;
        pidx_d    = pidx_q;
        it_x_d    = it_x_q;
        it_y_d    = it_y_q;
        it_idx_d  = it_idx_q;
        w_d       = w_q;
        h_d       = h_q;
        n_d       = n_q;
        id_d      = id_q;
        fwd_d     = fwd_q;
        right_d   = right_q;
        up_d      = up_q;
        if (state_q == RG_IDLE) begin
            if (start && !abort) begin
                w_d     = image_width;
                h_d     = image_height;
                n_d     = num_cores;
                id_d    = core_id;
                fwd_d   = {cam_fwd_x, cam_fwd_y, cam_fwd_z};
                right_d = {cam_right_x, cam_right_y, cam_right_z};
                up_d    = {cam_up_x, cam_up_y, cam_up_z};
                if (cfg_bad) begin
                    cfg_err_d = 1'b1;
                end else if (id_ge_wh) begin
                    done_d = 1'b1;
                end else begin
                    state_d = RG_INIT;
                    busy_d  = 1'b1;
                end
            end
        end else if (state_q == RG_INIT) begin
            it_x_d   = DIM_W'(id_q);
            it_y_d   = '0;
            it_idx_d = IDX_W'(id_q);
            state_d  = RG_RUN;
        end else begin
            if (valid_q && ray_ready && last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = RG_IDLE;
            end else if (!valid_q || ray_ready) begin
                // Output slot is empty or draining: load the next pixel and advance the walker.
                valid_d  = 1'b1;
                last_d   = last_nxt;
                dir_x_d  = mac_x;
                dir_y_d  = mac_y;
                dir_z_d  = mac_z;
                px_d     = it_x_q;
                py_d     = it_y_q;
                pidx_d   = it_idx_q;
                it_x_d   = DIM_W'(wrap ? xs - {1'b0, w_q} : xs);
                it_y_d   = wrap ? it_y_q + 1'b1 : it_y_q;
                it_idx_d = IDX_W'(idx_n);
            end
        end
        if (abort && state_q != RG_IDLE) begin
            state_d = RG_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RG_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            dir_x_q   <= '0;
            dir_y_q   <= '0;
            dir_z_q   <= '0;
            px_q      <= '0;
            py_q      <= '0;
            pidx_q    <= '0;
            it_x_q    <= '0;
            it_y_q    <= '0;
            it_idx_q  <= '0;
            w_q       <= '0;
            h_q       <= '0;
            n_q       <= '0;
            id_q      <= '0;
            fwd_q     <= '0;
            right_q   <= '0;
            up_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            dir_z_q   <= dir_z_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pidx_q    <= pidx_d;
            it_x_q    <= it_x_d;
            it_y_q    <= it_y_d;
            it_idx_q  <= it_idx_d;
            w_q       <= w_d;
            h_q       <= h_d;
            n_q       <= n_d;
            id_q      <= id_d;
            fwd_q     <= fwd_d;
            right_q   <= right_d;
            up_q      <= up_d;
        end
    end

    assign ray_valid   = valid_q;
    assign ray_dir_x   = dir_x_q;
    assign ray_dir_y   = dir_y_q;
    assign ray_dir_z   = dir_z_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign pixel_index = pidx_q;
    assign ray_last    = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
endmodule
